// File: rtl/simple_uart_pkg.sv
// Shared UART definitions: parity modes, transmitter states and default timing.
package simple_uart_pkg;

    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_EVEN = 2'd1,
        PAR_ODD  = 2'd2
    } parity_t;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP
    } tx_state_t;

    localparam int DEF_CLKS_PER_BIT = 16;
    localparam int DEF_DATA_BITS    = 8;

    // Parity bit for up to 8 payload bits; narrower payloads are zero-extended.
    function automatic logic frame_parity(input logic [7:0] d, input parity_t mode);
        return (^d) ^ (mode == PAR_ODD);
    endfunction

endpackage

// File: rtl/simple_uart_bitclk.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 while enabled, pulses bit_done on the last cycle.
module simple_uart_bitclk #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic en,
    output logic bit_done
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt;

    always_comb bit_done = en && (cnt == LAST);

    always_ff @(posedge clk) begin
        if (!reset || clear) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= bit_done ? '0 : cnt + CW'(1);
        end
    end

endmodule

// File: rtl/simple_uart_tx.sv
// UART transmitter: valid/ready byte in, start + LSB-first data + optional parity + stop bits out.
module simple_uart_tx
    import simple_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
    parameter int DATA_BITS    = DEF_DATA_BITS,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DATA_BITS-1:0] data,
    input  logic                 data_valid,
    output logic                 ready,
    output logic                 tx,
    output logic                 busy
);

    localparam int BW = $clog2(DATA_BITS + 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);
    localparam parity_t PAR_MODE = parity_t'(PARITY);
    localparam logic LAST_STOP = (STOP_BITS == 2);

    tx_state_t            state, state_n;
    logic [DATA_BITS-1:0] shift, shift_n;
    logic [BW-1:0]        bit_cnt, bit_cnt_n;
    logic                 stop_cnt, stop_cnt_n;
    logic                 par_bit, par_n;
    logic                 tx_n;
    logic                 bit_done;
    logic                 handshake;

    simple_uart_bitclk #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_bitclk (
        .clk      (clk),
        .reset    (reset),
        .clear    (handshake),
        .en       (state != TX_IDLE),
        .bit_done (bit_done)
    );

    // Ready in the last stop cycle lets a new frame start with no idle gap.
    always_comb begin
        ready = reset && ((state == TX_IDLE) ||
                          (state == TX_STOP && bit_done && stop_cnt == LAST_STOP));
        handshake = data_valid && ready;
    end

    always_comb begin
        state_n    = state;
        shift_n    = shift;
        bit_cnt_n  = bit_cnt;
        stop_cnt_n = stop_cnt;
        par_n      = par_bit;
        tx_n       = tx;
        case (state)
            TX_IDLE: begin
                tx_n = 1'b1;
            end
            TX_START: begin
                if (bit_done) begin
                    state_n   = TX_DATA;
                    tx_n      = shift[0];
                    bit_cnt_n = '0;
                end
            end
            TX_DATA: begin
                if (bit_done) begin
                    if (bit_cnt == LAST_BIT) begin
                        if (PAR_MODE != PAR_NONE) begin
                            state_n = TX_PARITY;
                            tx_n    = par_bit;
                        end else begin
                            state_n    = TX_STOP;
                            tx_n       = 1'b1;
                            stop_cnt_n = 1'b0;
                        end
                    end else begin
                        shift_n   = shift >> 1;
                        tx_n      = shift[1];
                        bit_cnt_n = bit_cnt + BW'(1);
                    end
                end
            end
            TX_PARITY: begin
                if (bit_done) begin
                    state_n    = TX_STOP;
                    tx_n       = 1'b1;
                    stop_cnt_n = 1'b0;
                end
            end
            TX_STOP: begin
                if (bit_done) begin
                    if (stop_cnt == LAST_STOP) begin
                        state_n = TX_IDLE;
                        tx_n    = 1'b1;
                    end else begin
                        stop_cnt_n = stop_cnt + 1'b1;
                    end
                end
            end
            default: begin
                state_n = TX_IDLE;
                tx_n    = 1'b1;
            end
        endcase
        // Handshake overrides the idle/stop transitions above; start bit goes out next cycle.
        if (handshake) begin
            state_n   = TX_START;
            tx_n      = 1'b0;
            shift_n   = data;
            par_n     = frame_parity(8'(data), PAR_MODE);
            bit_cnt_n = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= TX_IDLE;
            shift    <= '0;
            bit_cnt  <= '0;
            stop_cnt <= 1'b0;
            par_bit  <= 1'b0;
            tx       <= 1'b1;
            busy     <= 1'b0;
        end else begin
            state    <= state_n;
            shift    <= shift_n;
            bit_cnt  <= bit_cnt_n;
            stop_cnt <= stop_cnt_n;
            par_bit  <= par_n;
            tx       <= tx_n;
            busy     <= (state_n != TX_IDLE);
        end
    end

endmodule

// File: tb/tb_simple_uart_tx.sv
// Directed bench for simple_uart_tx: framing, back-to-back, ignore, abort and parity cases.
module tb_simple_uart_tx;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] data = 8'h00;
    logic       data_valid = 1'b0;
    logic [7:0] dp = 8'h00;
    logic       dvp = 1'b0;
    logic       ready, tx, busy;
    logic       rdy_o, tx_o, busy_o;
    logic       rdy_e, tx_e, busy_e;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    simple_uart_tx #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut (
        .clk(clk), .reset(reset), .data(data), .data_valid(data_valid),
        .ready(ready), .tx(tx), .busy(busy)
    );

    simple_uart_tx #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) dut_odd (
        .clk(clk), .reset(reset), .data(dp), .data_valid(dvp),
        .ready(rdy_o), .tx(tx_o), .busy(busy_o)
    );

    simple_uart_tx #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) dut_even (
        .clk(clk), .reset(reset), .data(dp), .data_valid(dvp),
        .ready(rdy_e), .tx(tx_e), .busy(busy_e)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_main(input string tag, input logic [7:0] d);
        data = d;
        data_valid = 1'b1;
        #1;
        check({tag, "_ready"}, ready, 1'b1);
        tick();
    endtask

    // Called just after the handshake edge; walks all 40 cycles of a no-parity frame.
    task automatic frame_main(input string tag, input logic [7:0] d, input bit mid,
                              input bit chain, input logic [7:0] nxt);
        logic [9:0] bits;
        logic [3:0] samp;
        int busy_lo;
        int rdy_bad;
        bits = {1'b1, d, 1'b0};
        busy_lo = 0;
        rdy_bad = 0;
        data_valid = mid;
        data = mid ? ~d : d;
        for (int b = 0; b < 10; b++) begin
            for (int c = 0; c < 4; c++) begin
                samp[c] = tx;
                if (busy !== 1'b1) busy_lo++;
                if (ready !== ((b == 9) && (c == 3))) rdy_bad++;
                if (b == 9 && c == 3) begin
                    if (chain) begin
                        data = nxt;
                        data_valid = 1'b1;
                    end else begin
                        data_valid = 1'b0;
                    end
                end
                tick();
            end
            check($sformatf("%s_bit%0d", tag, b), samp, {4{bits[b]}});
        end
        check({tag, "_busy_lo"}, busy_lo, 0);
        check({tag, "_ready_pattern"}, rdy_bad, 0);
        if (chain) begin
            check({tag, "_b2b_busy"}, busy, 1'b1);
            check({tag, "_b2b_start"}, tx, 1'b0);
        end else begin
            check({tag, "_end_busy"}, busy, 1'b0);
            check({tag, "_end_tx"}, tx, 1'b1);
        end
    endtask

    initial begin
        int bad;
        int bo, be;
        logic [3:0] po, pe;
        logic d0, d3;

        // Reset and idle
        repeat (3) tick();
        check("rst_ready", ready, 1'b0);
        check("rst_tx", tx, 1'b1);
        check("rst_busy", busy, 1'b0);
        reset = 1'b1;
        #1;
        check("rel_ready", ready, 1'b1);
        check("rel_tx", tx, 1'b1);
        check("rel_busy", busy, 1'b0);
        tick();

        // Single byte
        start_main("a5", 8'hA5);
        frame_main("a5", 8'hA5, 1'b0, 1'b0, 8'h00);
        repeat (2) tick();

        // Back-to-back: valid held high through the first frame
        start_main("b2b0", 8'h00);
        frame_main("b2b0", 8'h00, 1'b1, 1'b1, 8'hFF);
        frame_main("b2b1", 8'hFF, 1'b0, 1'b0, 8'h00);

        // Valid and changing data while busy are ignored
        start_main("ig", 8'h5A);
        frame_main("ig", 8'h5A, 1'b1, 1'b0, 8'h00);
        bad = 0;
        repeat (8) begin
            if (tx !== 1'b1 || busy !== 1'b0) bad++;
            tick();
        end
        check("ig_no_second_frame", bad, 0);

        // Reset mid-DATA aborts the frame
        start_main("ab", 8'h00);
        data_valid = 1'b0;
        repeat (8) tick();
        check("ab_mid_tx", tx, 1'b0);
        check("ab_mid_busy", busy, 1'b1);
        reset = 1'b0;
        tick();
        check("ab_tx", tx, 1'b1);
        check("ab_busy", busy, 1'b0);
        check("ab_ready", ready, 1'b0);
        reset = 1'b1;
        #1;
        check("ab_rel_ready", ready, 1'b1);
        bad = 0;
        repeat (20) begin
            if (tx !== 1'b1 || busy !== 1'b0) bad++;
            tick();
        end
        check("ab_no_resume", bad, 0);

        // Reset wins over a simultaneous handshake
        reset = 1'b0;
        data = 8'h55;
        data_valid = 1'b1;
        tick();
        reset = 1'b1;
        data_valid = 1'b0;
        #1;
        check("rw_busy", busy, 1'b0);
        check("rw_tx", tx, 1'b1);
        tick();
        check("rw_idle_busy", busy, 1'b0);

        // Parity: 8'h07 has odd popcount -> odd bit 0, even bit 1
        dp = 8'h07;
        dvp = 1'b1;
        #1;
        check("par_ready_o", rdy_o, 1'b1);
        check("par_ready_e", rdy_e, 1'b1);
        tick();
        dvp = 1'b0;
        dp = 8'hF8;
        bo = 0;
        be = 0;
        bad = 0;
        po = '0;
        pe = '0;
        d0 = 1'b0;
        d3 = 1'b1;
        for (int i = 0; i < 44; i++) begin
            if (i >= 36 && i < 40) begin
                po[i-36] = tx_o;
                pe[i-36] = tx_e;
            end
            if (i == 5) d0 = tx_e;
            if (i == 17) d3 = tx_e;
            if (busy_o === 1'b1) bo++;
            if (busy_e === 1'b1) be++;
            if (rdy_o !== (i == 43)) bad++;
            tick();
        end
        check("par_odd_bit", po, 4'b0000);
        check("par_even_bit", pe, 4'b1111);
        check("par_data_bit0", d0, 1'b1);
        check("par_data_bit3", d3, 1'b0);
        check("par_len_odd", bo, 44);
        check("par_len_even", be, 44);
        check("par_ready_pattern", bad, 0);
        check("par_end_busy_o", busy_o, 1'b0);
        check("par_end_tx_e", tx_e, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
